// File: rtl/mux_4to1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_rr
// Purpose  : Four-channel valid/ready merge with round-robin arbitration and
//            a single registered output stage that tracks the channel source.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  // EMPTY/FULL is exactly the out_valid flag of the output register
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  last_grant;
  logic [1:0]  grant;
  logic [1:0]  probe;
  logic        found;
  logic        any_valid;
  logic        load_en;
  logic        take;

  assign out_valid = (state == FULL);
  assign any_valid = |in_valid;
  // The register may load when it is empty or being drained this cycle
  assign load_en   = !out_valid || out_ready;
  // Reset gates acceptance so nothing is handshaken while rst is high
  assign take      = load_en && any_valid && !rst;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    grant = last_grant;
    probe = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      probe = last_grant + 2'(k);
      if (!found && in_valid[probe]) begin
        grant = probe;
        found = 1'b1;
      end
    end
  end

  // One-hot acceptance strobe for the winning channel
  always_comb begin
    in_ready = 4'b0000;
    if (take) begin
      in_ready = 4'b0001 << grant;
    end
  end

  // Next-state: reload decides FULL vs EMPTY, otherwise hold
  always_comb begin
    state_next = state;
    if (load_en) begin
      state_next = any_valid ? FULL : EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output data, source index and arbitration pointer update on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_sel    <= 2'd0;
      last_grant <= 2'd3;
    end else if (take) begin
      out_data   <= in_data[int'(grant)*DATA_W +: DATA_W];
      out_sel    <= grant;
      last_grant <= grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1_rr
// Purpose  : Scoreboard bench for the round-robin four-channel merge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4to1_rr;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_ready;

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [1:0]  m_last;
  logic        m_full;
  logic [9:0]  sb_q[$];   // {sel, data}

  mux_4to1_rr #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive, compare against model, advance model
  task automatic cycle(input logic [3:0] v, input logic [31:0] d,
                       input logic r, input logic rs);
    logic [3:0] exp_ready;
    logic [1:0] g;
    logic [1:0] p;
    logic       fnd;
    logic       le;
    logic [9:0] front;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #1;
    le  = !m_full || r;
    g   = m_last;
    fnd = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      p = m_last + 2'(k);
      if (!fnd && v[p]) begin
        g   = p;
        fnd = 1'b1;
      end
    end
    exp_ready = (!rs && le && (v != 4'b0)) ? (4'b0001 << g) : 4'b0000;
    n_cmp++;
    if (in_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL in_ready got %b exp %b (t=%0t)", in_ready, exp_ready, $time);
    end
    n_cmp++;
    if (out_valid !== m_full) begin
      n_fail++;
      $display("FAIL out_valid got %b exp %b (t=%0t)", out_valid, m_full, $time);
    end
    if (m_full) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard empty while output expected full (t=%0t)", $time);
      end else begin
        front = sb_q[0];
        n_cmp++;
        if ({out_sel, out_data} !== front) begin
          n_fail++;
          $display("FAIL out_word got sel=%0d data=%h exp sel=%0d data=%h (t=%0t)",
                   out_sel, out_data, front[9:8], front[7:0], $time);
        end
        if (r && !rs) void'(sb_q.pop_front());
      end
    end
    if (rs) begin
      m_full = 1'b0;
      m_last = 2'd3;
      sb_q.delete();
    end else if (le) begin
      if (v != 4'b0) begin
        sb_q.push_back({g, d[int'(g)*8 +: 8]});
        m_full = 1'b1;
        m_last = g;
      end else begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    cycle(4'b0000, 32'h0, 1'b0, 1'b1);
    cycle(4'b1111, 32'hDEADBEEF, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_sel, out_data} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b sel=%0d data=%h exp all zero",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 6; i++) cycle(4'b1111, 32'h13121110, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    cycle(4'b0100, 32'h00A50000, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready got %b exp 0100", in_ready);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_out got v=%b sel=%0d data=%h exp v=1 sel=2 data=a5",
               out_valid, out_sel, out_data);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    cycle(4'b1111, 32'h44332211, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 32'h44332211, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 32'h44332211, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_fairness();
    cycle(4'b0000, 32'h0, 1'b0, 1'b1);
    cycle(4'b0011, 32'h000000B0 | 32'h0000B100, 1'b1, 1'b0);
    cycle(4'b0010, 32'h0000B100, 1'b1, 1'b0);
    cycle(4'b1001, 32'hC30000C0, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL fair_first got %b exp 1000", in_ready);
    end
    cycle(4'b1001, 32'hC30000C0, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL fair_second got %b exp 0001", in_ready);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_drain();
    cycle(4'b0001, 32'h0000005A, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty got %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    cycle(4'b1111, 32'h77665544, 1'b1, 1'b0);
    cycle(4'b1111, 32'h77665544, 1'b0, 1'b0);
    cycle(4'b1111, 32'h77665544, 1'b0, 1'b1);
    cycle(4'b1111, 32'h77665544, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_grant got %b exp 0001", in_ready);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'h44}) begin
      n_fail++;
      $display("FAIL post_reset_out got v=%b sel=%0d data=%h exp v=1 sel=0 data=44",
               out_valid, out_sel, out_data);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0]  v;
    logic [31:0] d;
    for (int i = 0; i < 200; i++) begin
      v = 4'($urandom_range(0, 15));
      d = $urandom;
      cycle(v, d, 1'($urandom_range(0, 1)), 1'b0);
    end
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
    cycle(4'b0000, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    m_last    = 2'd3;
    m_full    = 1'b0;
    rst       = 1'b1;
    in_valid  = 4'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_fairness();
    test_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_4to1_rr.md
MUX_4TO1_RR -- requirements
Module: mux_4to1_rr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of the data on every channel.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 4 bits: bit i set means channel i offers data.
REQ-005 SHALL have port in_data, input, 4*DATA_W bits: channel i data in bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port in_ready, output, 4 bits: bit i set means channel i is accepted this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-008 SHALL have port out_data, output, DATA_W bits: the merged data word.
REQ-009 SHALL have port out_sel, output, 2 bits: index of the channel that sourced out_data.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumes the word when out_valid is also high.

Function
REQ-011 SHALL transfer on input channel i when in_valid[i] and in_ready[i] are both high at a rising clk.
REQ-012 SHALL transfer on the output when out_valid and out_ready are both high at a rising clk.
REQ-013 SHALL define load_en = !out_valid || out_ready, evaluated combinationally.
REQ-014 SHALL have two states, carried by out_valid:
- EMPTY (out_valid = 0).
- FULL (out_valid = 1).
REQ-015 SHALL choose the grant as the first i with in_valid[i] = 1, searching in the order last_grant+1, last_grant+2, last_grant+3, last_grant (mod 4).
REQ-016 SHALL drive in_ready one-hot on the granted channel when load_en = 1 and any in_valid bit is high; otherwise in_ready SHALL be 4'b0000.
REQ-017 SHALL compute in_ready combinationally from in_valid, last_grant, out_valid and out_ready, with no dependence on in_data.
REQ-018 SHALL, on an input transfer, do all of the following at the same edge:
- load out_data with the granted channel's data;
- load out_sel with the grant index;
- set out_valid to 1;
- set last_grant to the grant index.
REQ-019 SHALL, when load_en = 1 and in_valid = 0, clear out_valid to 0 at the edge and leave out_data, out_sel and last_grant unchanged.
REQ-020 SHALL, when out_valid = 1 and out_ready = 0, hold out_valid, out_data, out_sel and last_grant stable.
REQ-021 SHALL have a latency of exactly one cycle from an input transfer to out_valid = 1 with that data.
REQ-022 SHALL sustain one word per cycle when out_ready is held at 1 and requests are present, with no bubble cycles.
REQ-023 SHALL, for simultaneous output consumption and input acceptance in one cycle, replace the consumed word with the new word with no gap.
REQ-024 SHALL never assert in_ready on a channel whose in_valid is 0.
REQ-025 SHALL never transfer more than one input per cycle.
REQ-026 SHALL never drop a word that has been accepted, and SHALL never duplicate one.

Reset
REQ-027 SHALL, while rst = 1 at a rising clk, set out_valid = 0, out_data = 0, out_sel = 0 and last_grant = 3.
REQ-028 SHALL hold in_ready = 4'b0000 in every cycle where rst = 1.
REQ-029 SHALL, when reset is asserted mid-operation, discard any word held in the output register; the first grant after reset SHALL go to channel 0 if it is requesting.

Verification
REQ-030 SHALL be verified with these directed scenarios:
- Round robin: all in_valid = 4'b1111, out_ready = 1, data 8'h10/8'h11/8'h12/8'h13 -> out_sel 0,1,2,3,0 on consecutive cycles with the matching data, out_valid held at 1.
- Single channel: only in_valid[2] = 1 with 8'hA5 -> in_ready = 4'b0100 that cycle; next cycle out_valid = 1, out_data = 8'hA5, out_sel = 2.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with all channels requesting -> in_ready = 0 and outputs stable throughout; when out_ready rises, the next channel in order loads on that edge.
- Fairness: last_grant = 1, in_valid = 4'b1001 -> channel 3 granted first, then channel 0.
- Drain: single word accepted, then in_valid = 0 and out_ready = 1 -> out_valid is 1 for exactly one cycle, then returns to 0.
- Reset mid-stream: rst pulsed while out_valid = 1 -> out_valid = 0 on the next cycle; after release with in_valid = 4'b1111, first out_sel = 0.
